// File: rtl/approx_mult_seq_pkg.sv
// Shared types and elaboration helpers for the sequential approximate multiplier.
package approx_mult_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StNorm,
    StMult,
    StDenorm,
    StDone
  } state_e;

  // Width needed to count 0..w shifts.
  function automatic int unsigned cnt_width(int unsigned w);
    return $clog2(w + 1);
  endfunction

  function automatic bit k_legal(int unsigned w, int unsigned k);
    return (k >= 2) && (k <= w);
  endfunction

endpackage

// File: rtl/approx_mult_seq_if.sv
// Start/done request interface between a controller and the multiplier core.
interface approx_mult_seq_if #(
  parameter int unsigned WIDTH = 16
);
  logic                 start;
  logic                 exact;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   out;

  modport master (
    output start, exact, A, B,
    input  busy, done, out
  );

  modport slave (
    input  start, exact, A, B,
    output busy, done, out
  );
endinterface

// File: rtl/approx_mult_seq_normalizer.sv
// Operand register that left-shifts itself until its MSB is set, counting the shifts.
module approx_mult_seq_normalizer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift,
  output logic [WIDTH-1:0] value,
  output logic [CW-1:0]    count,
  output logic             is_zero,
  output logic             is_norm
);

  logic [WIDTH-1:0] value_q;
  logic [CW-1:0]    count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
      count_q <= '0;
    end else if (load) begin
      value_q <= load_val;
      count_q <= '0;
    end else if (shift && !value_q[WIDTH-1]) begin
      value_q <= value_q << 1;
      count_q <= count_q + CW'(1);
    end
  end

  assign value   = value_q;
  assign count   = count_q;
  assign is_zero = (value_q == '0);
  assign is_norm = value_q[WIDTH-1];

endmodule

// File: rtl/approx_mult_seq.sv
// Sequential unsigned multiplier: normalise, Keff-cycle shift-add on the top Keff bits,
// then denormalise into a 2*WIDTH result.
module approx_mult_seq
  import approx_mult_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned K     = 8
) (
  input logic              clk,
  input logic              rst,
  approx_mult_seq_if.slave bus
);

  localparam int unsigned CW   = cnt_width(WIDTH);
  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned Drop = WIDTH - K;
  localparam logic [CW-1:0] KExactM1  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] KApproxM1 = CW'(K - 1);

  if (!k_legal(WIDTH, K)) begin : gen_k_check
    $error("approx_mult_seq: K must lie in 2..WIDTH");
  end

  state_e           state;
  logic             busy_q;
  logic             done_q;
  logic [PW-1:0]    out_q;
  logic             mode_q;
  logic [PW-1:0]    acc_q;
  logic [PW-1:0]    mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CW-1:0]    step_q;

  logic             norm_load;
  logic             norm_shift;
  logic [WIDTH-1:0] a_val, b_val;
  logic [CW-1:0]    a_cnt, b_cnt;
  logic             a_zero, b_zero, a_norm, b_norm;

  logic [WIDTH-1:0] at, bt;
  logic [CW-1:0]    keff_m1;
  logic [CW:0]      cnt_sum;
  logic [PW-1:0]    scaled;
  logic [PW-1:0]    denorm;

  // Operands are captured in the start cycle so the requester may change A/B afterwards.
  assign norm_load  = (state == StIdle) && bus.start;
  assign norm_shift = (state == StNorm) && !(a_zero || b_zero);

  approx_mult_seq_normalizer #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_norm_a (
    .clk      (clk),
    .rst      (rst),
    .load     (norm_load),
    .load_val (bus.A),
    .shift    (norm_shift),
    .value    (a_val),
    .count    (a_cnt),
    .is_zero  (a_zero),
    .is_norm  (a_norm)
  );

  approx_mult_seq_normalizer #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_norm_b (
    .clk      (clk),
    .rst      (rst),
    .load     (norm_load),
    .load_val (bus.B),
    .shift    (norm_shift),
    .value    (b_val),
    .count    (b_cnt),
    .is_zero  (b_zero),
    .is_norm  (b_norm)
  );

  assign at      = mode_q ? a_val : (a_val >> Drop);
  assign bt      = mode_q ? b_val : (b_val >> Drop);
  assign keff_m1 = mode_q ? KExactM1 : KApproxM1;

  always_comb begin
    cnt_sum = {1'b0, a_cnt} + {1'b0, b_cnt};
    scaled  = mode_q ? acc_q : (acc_q << (2 * Drop));
    denorm  = scaled >> cnt_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= StIdle;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      out_q    <= '0;
      mode_q   <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      step_q   <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state  <= StLoad;
            busy_q <= 1'b1;
            mode_q <= bus.exact;
          end
        end
        StLoad: begin
          acc_q  <= '0;
          step_q <= '0;
          state  <= StNorm;
        end
        StNorm: begin
          if (a_zero || b_zero) begin
            out_q  <= '0;
            done_q <= 1'b1;
            state  <= StDone;
          end else if (a_norm && b_norm) begin
            mcand_q  <= PW'(at);
            mplier_q <= bt;
            acc_q    <= '0;
            step_q   <= '0;
            state    <= StMult;
          end
        end
        StMult: begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          step_q   <= step_q + CW'(1);
          if (step_q == keff_m1) state <= StDenorm;
        end
        StDenorm: begin
          out_q  <= denorm;
          done_q <= 1'b1;
          state  <= StDone;
        end
        StDone: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.out  = out_q;

endmodule

// File: tb/tb_approx_mult_seq.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and a random
// sweep against a truncate-to-top-K-significant-bits reference model.
module tb_approx_mult_seq;

  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start0 = 1'b0;
  logic          start1 = 1'b0;
  logic          exact_in = 1'b0;
  logic [W-1:0]  a_in = '0;
  logic [W-1:0]  b_in = '0;

  int n_checks = 0;
  int n_fail   = 0;

  approx_mult_seq_if #(.WIDTH(W)) bus0 ();
  approx_mult_seq_if #(.WIDTH(W)) bus1 ();

  assign bus0.start = start0;
  assign bus0.exact = exact_in;
  assign bus0.A     = a_in;
  assign bus0.B     = b_in;
  assign bus1.start = start1;
  assign bus1.exact = exact_in;
  assign bus1.A     = a_in;
  assign bus1.B     = b_in;

  approx_mult_seq #(.WIDTH(W), .K(8)) dut_k8 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  approx_mult_seq #(.WIDTH(W), .K(W)) dut_kw (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    bit          ex;
    logic [31:0] exp_out;
    int          exp_cyc;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference model: keep only the top k significant bits of each operand, multiply.
  function automatic int lz16(logic [15:0] v);
    for (int i = 15; i >= 0; i--) if (v[i]) return 15 - i;
    return 16;
  endfunction

  function automatic logic [15:0] keep_top(logic [15:0] v, int k);
    int nbits;
    nbits = 16 - lz16(v);
    if (nbits <= k) return v;
    return (v >> (nbits - k)) << (nbits - k);
  endfunction

  function automatic logic [31:0] ref_out(logic [15:0] a, logic [15:0] b, bit ex, int k);
    if (ex) return 32'(a) * 32'(b);
    return 32'(keep_top(a, k)) * 32'(keep_top(b, k));
  endfunction

  function automatic int ref_cyc(logic [15:0] a, logic [15:0] b, int keff);
    int la, lb;
    if (a == 0 || b == 0) return 3;
    la = lz16(a);
    lb = lz16(b);
    return ((la > lb) ? la : lb) + keff + 4;
  endfunction

  // Start in cycle 0, return the cycle in which done rose (-1 on timeout).
  task automatic run_op(input bit sel, input logic [15:0] a, input logic [15:0] b,
                        input bit ex, input bit glitch, output logic [31:0] got,
                        output int cyc, output bit busy_ok, output bit idle_ok);
    logic d, bz;
    a_in = a;
    b_in = b;
    exact_in = ex;
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    cyc = -1;
    busy_ok = 1'b1;
    got = '0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (i == 1 || (glitch && (i == 4 || i == 15))) begin
        start0 = 1'b0;
        start1 = 1'b0;
      end
      if (glitch && (i == 3 || i == 14)) begin
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        a_in = 16'($urandom);
        b_in = 16'($urandom);
        exact_in = !ex;
      end
      d  = sel ? bus1.done : bus0.done;
      bz = sel ? bus1.busy : bus0.busy;
      if (!bz) busy_ok = 1'b0;
      if (d) begin
        got = sel ? bus1.out : bus0.out;
        cyc = i;
        break;
      end
    end
    start0 = 1'b0;
    start1 = 1'b0;
    @(posedge clk); #1;
    idle_ok = sel ? (!bus1.busy && !bus1.done) : (!bus0.busy && !bus0.done);
  endtask

  task automatic exec(input string name, input bit sel, input logic [15:0] a,
                      input logic [15:0] b, input bit ex, input bit glitch,
                      input logic [31:0] exp_out, input int exp_cyc, output logic [31:0] got);
    int  cyc;
    bit  busy_ok, idle_ok;
    run_op(sel, a, b, ex, glitch, got, cyc, busy_ok, idle_ok);
    check({name, ".out"}, 64'(got), 64'(exp_out));
    check({name, ".cycle"}, 64'(cyc), 64'(exp_cyc));
    check({name, ".busy"}, 64'(busy_ok), 64'd1);
    check({name, ".idle_after"}, 64'(idle_ok), 64'd1);
  endtask

  initial begin
    vec_t        vecs[$];
    logic [31:0] got;
    logic [15:0] ra, rb;
    bit          rex;
    int          t1, t2, cyc;

    vecs.push_back('{16'h0300, 16'h0050, 1'b0, 32'h0000F000, 21});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 32'hFE010000, 12});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 32'hFFFE0001, 20});
    vecs.push_back('{16'h0000, 16'h1234, 1'b0, 32'h00000000, 3});
    vecs.push_back('{16'h0000, 16'h1234, 1'b1, 32'h00000000, 3});
    vecs.push_back('{16'h1234, 16'h0000, 1'b0, 32'h00000000, 3});
    vecs.push_back('{16'h1234, 16'h0000, 1'b1, 32'h00000000, 3});
    vecs.push_back('{16'h0001, 16'h0001, 1'b0, 32'h00000001, 27});
    vecs.push_back('{16'h0001, 16'h0001, 1'b1, 32'h00000001, 35});
    vecs.push_back('{16'h8000, 16'h8000, 1'b0, 32'h40000000, 12});

    repeat (3) @(posedge clk);
    #1;
    check("reset.busy", 64'(bus0.busy), 64'd0);
    check("reset.done", 64'(bus0.done), 64'd0);
    check("reset.out", 64'(bus0.out), 64'd0);
    check("reset.out_kw", 64'(bus1.out), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i])
      exec($sformatf("vec%0d", i), 1'b0, vecs[i].a, vecs[i].b, vecs[i].ex, 1'b0,
           vecs[i].exp_out, vecs[i].exp_cyc, got);

    // start/new operands pulsed during NORM and MULT must not disturb the first request
    exec("ignore_start", 1'b0, 16'h0300, 16'h0050, 1'b0, 1'b1, 32'h0000F000, 21, got);

    // start held high: next operation begins as soon as the FSM is back in IDLE
    a_in = 16'h8000;
    b_in = 16'h8000;
    exact_in = 1'b0;
    start0 = 1'b1;
    t1 = -1;
    t2 = -1;
    for (int i = 1; i <= 100 && t2 < 0; i++) begin
      @(posedge clk); #1;
      if (bus0.done) begin
        if (t1 < 0) t1 = i; else t2 = i;
      end
      if (t2 >= 0) start0 = 1'b0;
    end
    start0 = 1'b0;
    check("hold.first_done", 64'(t1), 64'd12);
    check("hold.gap", 64'(t2 - t1), 64'd13);
    check("hold.out", 64'(bus0.out), 64'h40000000);
    repeat (2) @(posedge clk);
    #1;

    // reset in NORM discards the in-flight operation
    a_in = 16'h0001;
    b_in = 16'h0001;
    exact_in = 1'b0;
    start0 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      start0 = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_norm.busy", 64'(bus0.busy), 64'd0);
    check("rst_norm.done", 64'(bus0.done), 64'd0);
    check("rst_norm.out", 64'(bus0.out), 64'd0);
    cyc = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (bus0.done) cyc++;
    end
    check("rst_norm.no_done", 64'(cyc), 64'd0);
    exec("after_rst", 1'b0, 16'h0300, 16'h0050, 1'b0, 1'b0, 32'h0000F000, 21, got);

    // random sweep, K=8 build
    for (int i = 0; i < 40; i++) begin
      ra  = 16'($urandom) >> $urandom_range(0, 16);
      rb  = 16'($urandom) >> $urandom_range(0, 16);
      rex = 1'($urandom);
      exec($sformatf("rand%0d", i), 1'b0, ra, rb, rex, 1'b0, ref_out(ra, rb, rex, 8),
           ref_cyc(ra, rb, rex ? 16 : 8), got);
      if (!rex) check($sformatf("rand%0d.le_exact", i), 64'(got <= 32'(ra) * 32'(rb)), 64'd1);
    end

    // K=WIDTH build is exact in both modes
    for (int i = 0; i < 16; i++) begin
      ra  = 16'($urandom) >> $urandom_range(0, 16);
      rb  = 16'($urandom) >> $urandom_range(0, 16);
      rex = 1'($urandom);
      exec($sformatf("kw%0d", i), 1'b1, ra, rb, rex, 1'b0, 32'(ra) * 32'(rb),
           ref_cyc(ra, rb, 16), got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
